// File: rtl/speaker_pdm_beeper.sv
// Egg-timer alarm beeper: a beep-cadence FSM gates a square-wave tone into a
// first-order sigma-delta modulator that drives the 1-bit PDM audio output.
module speaker_pdm_beeper #(
  parameter int unsigned TONE_HALF_CYCLES = 1250,
  parameter int unsigned BEEP_ON_CYCLES   = 250000,
  parameter int unsigned BEEP_OFF_CYCLES  = 250000,
  parameter int unsigned NUM_BEEPS        = 3
) (
  input  logic       pulse_2dot5MHz,
  input  logic       reset,
  input  logic       enable_speaker,
  input  logic       trigger,
  input  logic [7:0] volume,
  output logic       busy,
  output logic [3:0] beeps_done,
  output logic       AUD_PWM,
  output logic       AUD_SD
);

  localparam int unsigned MAX_IVL = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ?
                                    BEEP_ON_CYCLES : BEEP_OFF_CYCLES;
  localparam int unsigned CW = (MAX_IVL > 1) ? $clog2(MAX_IVL) : 1;
  localparam int unsigned TW = $clog2(TONE_HALF_CYCLES);

  typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tone_cnt_q, tone_cnt_d;
  logic          tone_hi_q, tone_hi_d;
  logic          busy_q, busy_d;
  logic          sd_q, sd_d;
  logic          pwm_q, pwm_d;
  logic [7:0]    acc_q, acc_d;
  logic [3:0]    beeps_q, beeps_d;

  logic          on_last, off_last, tone_last, last_beep;
  logic [7:0]    sample;
  logic [8:0]    sum;

  assign on_last   = (cnt_q == CW'(BEEP_ON_CYCLES - 1));
  assign off_last  = (cnt_q == CW'(BEEP_OFF_CYCLES - 1));
  assign tone_last = (tone_cnt_q == TW'(TONE_HALF_CYCLES - 1));
  assign last_beep = ((beeps_q + 4'd1) == 4'(NUM_BEEPS));

  always_ff @(posedge pulse_2dot5MHz or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_speaker) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (trigger) state_d = BEEP_ON;
        BEEP_ON:  if (on_last) state_d = last_beep ? IDLE : BEEP_OFF;
        BEEP_OFF: if (off_last) state_d = BEEP_ON;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    tone_cnt_d = tone_cnt_q;
    tone_hi_d  = tone_hi_q;
    busy_d     = busy_q;
    sd_d       = sd_q;
    beeps_d    = beeps_q;
    sample     = (state_q == BEEP_ON && tone_hi_q) ? volume : '0;
    sum        = {1'b0, acc_q} + {1'b0, sample};
    pwm_d      = sum[8];
    acc_d      = sum[7:0];
    if (!enable_speaker) begin
      busy_d = 1'b0;
      sd_d   = 1'b0;
      pwm_d  = 1'b0;
      acc_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            beeps_d    = '0;
            cnt_d      = '0;
            tone_cnt_d = '0;
            tone_hi_d  = 1'b1;
            busy_d     = 1'b1;
            sd_d       = 1'b1;
          end
        end
        BEEP_ON: begin
          if (tone_last) begin
            tone_cnt_d = '0;
            tone_hi_d  = ~tone_hi_q;
          end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
          end
          if (on_last) begin
            beeps_d = beeps_q + 4'd1;
            cnt_d   = '0;
            if (last_beep) begin
              busy_d = 1'b0;
              sd_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BEEP_OFF: begin
          if (off_last) begin
            cnt_d      = '0;
            tone_cnt_d = '0;
            tone_hi_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pulse_2dot5MHz or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      tone_cnt_q <= '0;
      tone_hi_q  <= 1'b0;
      busy_q     <= 1'b0;
      sd_q       <= 1'b0;
      pwm_q      <= 1'b0;
      acc_q      <= '0;
      beeps_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_hi_q  <= tone_hi_d;
      busy_q     <= busy_d;
      sd_q       <= sd_d;
      pwm_q      <= pwm_d;
      acc_q      <= acc_d;
      beeps_q    <= beeps_d;
    end
  end

  assign busy       = busy_q;
  assign beeps_done = beeps_q;
  assign AUD_PWM    = pwm_q;
  assign AUD_SD     = sd_q;

endmodule

// File: tb/tb_speaker_pdm_beeper.sv
// Directed bench for speaker_pdm_beeper: cadence, tone/PDM pattern, density,
// trigger handling, enable abort and asynchronous reset.
module tb_speaker_pdm_beeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, trig;
  logic [7:0] vol;
  logic       busy, pwm, sd;
  logic [3:0] bd;

  logic       en2, trig2;
  logic [7:0] vol2;
  logic       busy2, pwm2, sd2;
  logic [3:0] bd2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  speaker_pdm_beeper #(
    .TONE_HALF_CYCLES(4), .BEEP_ON_CYCLES(32), .BEEP_OFF_CYCLES(16), .NUM_BEEPS(2)
  ) dut (
    .pulse_2dot5MHz(clk), .reset(rst), .enable_speaker(en), .trigger(trig),
    .volume(vol), .busy(busy), .beeps_done(bd), .AUD_PWM(pwm), .AUD_SD(sd)
  );

  speaker_pdm_beeper #(
    .TONE_HALF_CYCLES(512), .BEEP_ON_CYCLES(1024), .BEEP_OFF_CYCLES(16), .NUM_BEEPS(2)
  ) dut2 (
    .pulse_2dot5MHz(clk), .reset(rst), .enable_speaker(en2), .trigger(trig2),
    .volume(vol2), .busy(busy2), .beeps_done(bd2), .AUD_PWM(pwm2), .AUD_SD(sd2)
  );

  // Expected PDM bit after edge k of a sequence at volume 128 with T=4, ON=32, OFF=16.
  function automatic logic exp_pwm128(input int k);
    int j, ph;
    if (k < 1) return 1'b0;
    j = k - 1;
    if (j < 32) ph = j;
    else if (j >= 48 && j < 80) ph = j - 48;
    else return 1'b0;
    return (((ph / 4) % 2) == 0) && ((ph % 2) == 1);
  endfunction

  task automatic pulse_trigger();
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
  endtask

  task automatic abort_dut();
    en = 1'b0;
    @(negedge clk) en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, sd, pwm, bd, busy2, sd2, pwm2, bd2} !== 14'd0) begin
      fails++;
      $display("FAIL reset_hold: got %b required 0", {busy, sd, pwm, bd, busy2, sd2, pwm2, bd2});
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, sd, pwm, bd} !== 7'd0) begin
        fails++;
        $display("FAIL idle_cycle%0d: busy/sd/pwm/bd=%b required 0", i, {busy, sd, pwm, bd});
      end
    end
  endtask

  task automatic test_full_sequence();
    logic eb, ep;
    logic [3:0] ebd;
    vol = 8'd128;
    pulse_trigger();
    for (int k = 0; k <= 85; k++) begin
      if (k > 0) @(negedge clk);
      eb  = (k < 80);
      ebd = (k < 32) ? 4'd0 : (k < 80) ? 4'd1 : 4'd2;
      ep  = exp_pwm128(k);
      tests++;
      if ({busy, sd, bd, pwm} !== {eb, eb, ebd, ep}) begin
        fails++;
        $display("FAIL full_seq k=%0d: busy=%b sd=%b bd=%0d pwm=%b required %b %b %0d %b",
                 k, busy, sd, bd, pwm, eb, eb, ebd, ep);
      end
    end
  endtask

  task automatic test_density();
    int ones;
    vol2 = 8'd255;
    @(negedge clk) trig2 = 1'b1;
    @(negedge clk) trig2 = 1'b0;
    tests++;
    if (busy2 !== 1'b1) begin
      fails++;
      $display("FAIL density_start: busy=%b required 1", busy2);
    end
    ones = 0;
    for (int k = 1; k <= 513; k++) begin
      @(negedge clk);
      if (k >= 2) ones += int'(pwm2);
    end
    tests++;
    if (ones < 509 || ones > 511) begin
      fails++;
      $display("FAIL density_255: ones=%0d required 510+-1", ones);
    end
    en2 = 1'b0;
    @(negedge clk) en2 = 1'b1;
    tests++;
    if ({busy2, sd2, pwm2} !== 3'b000) begin
      fails++;
      $display("FAIL density_abort: busy/sd/pwm=%b required 000", {busy2, sd2, pwm2});
    end
    vol2 = 8'd0;
    @(negedge clk) trig2 = 1'b1;
    @(negedge clk) trig2 = 1'b0;
    ones = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      ones += int'(pwm2);
    end
    tests++;
    if (ones != 0 || busy2 !== 1'b1) begin
      fails++;
      $display("FAIL density_0: ones=%0d busy=%b required 0 ones busy 1", ones, busy2);
    end
    en2 = 1'b0;
    @(negedge clk) en2 = 1'b1;
  endtask

  task automatic test_trigger_while_busy();
    int cycles;
    bit done;
    vol = 8'd64;
    pulse_trigger();
    cycles = busy ? 1 : 0;
    done = 1'b0;
    for (int k = 1; k <= 200 && !done; k++) begin
      if (k == 20) trig = 1'b1;
      if (k == 21) trig = 1'b0;
      @(negedge clk);
      if (busy) cycles++;
      else done = 1'b1;
    end
    tests++;
    if (!done || cycles != 80) begin
      fails++;
      $display("FAIL busy_retrigger: busy_cycles=%0d ended=%0d required 80 ended 1", cycles, done);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_retrigger_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_rearm();
    int cycles, low;
    bit done;
    @(negedge clk) trig = 1'b1;
    @(negedge clk);
    cycles = busy ? 1 : 0;
    done = 1'b0;
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      if (busy) cycles++;
      else done = 1'b1;
    end
    low = done ? 1 : 0;
    for (int k = 0; k < 5 && done; k++) begin
      @(negedge clk);
      if (busy) break;
      low++;
    end
    tests++;
    if (!done || cycles != 80 || low != 1 || busy !== 1'b1 || bd !== 4'd0) begin
      fails++;
      $display("FAIL rearm: busy_cycles=%0d idle_cycles=%0d busy=%b bd=%0d required 80 1 1 0",
               cycles, low, busy, bd);
    end
    trig = 1'b0;
    abort_dut();
  endtask

  task automatic test_abort();
    logic [3:0] ep;
    vol = 8'd128;
    pulse_trigger();
    for (int k = 1; k <= 39; k++) @(negedge clk);
    tests++;
    if ({busy, bd} !== {1'b1, 4'd1}) begin
      fails++;
      $display("FAIL abort_pre: busy=%b bd=%0d required 1 1", busy, bd);
    end
    en = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, sd, pwm, bd} !== {3'b000, 4'd1}) begin
      fails++;
      $display("FAIL abort: busy=%b sd=%b pwm=%b bd=%0d required 0 0 0 1", busy, sd, pwm, bd);
    end
    en = 1'b1;
    pulse_trigger();
    tests++;
    if ({busy, sd, bd} !== {2'b11, 4'd0}) begin
      fails++;
      $display("FAIL restart: busy=%b sd=%b bd=%0d required 1 1 0", busy, sd, bd);
    end
    ep = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if (pwm !== ep[4-k]) begin
        fails++;
        $display("FAIL restart_pwm k=%0d: pwm=%b required %b", k, pwm, ep[4-k]);
      end
    end
    abort_dut();
  endtask

  task automatic test_async_reset();
    vol = 8'd128;
    pulse_trigger();
    for (int k = 1; k <= 10; k++) @(negedge clk);
    tests++;
    if ({busy, sd, pwm} !== 3'b111) begin
      fails++;
      $display("FAIL pre_reset: busy/sd/pwm=%b required 111", {busy, sd, pwm});
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, sd, pwm, bd} !== 7'd0) begin
      fails++;
      $display("FAIL async_reset: busy/sd/pwm/bd=%b required 0", {busy, sd, pwm, bd});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, sd, pwm} !== 3'b000) begin
        fails++;
        $display("FAIL post_reset_idle%0d: busy/sd/pwm=%b required 000", i, {busy, sd, pwm});
      end
    end
    pulse_trigger();
    tests++;
    if ({busy, bd} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL post_reset_start: busy=%b bd=%0d required 1 0", busy, bd);
    end
    abort_dut();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; trig = 1'b0; vol = '0;
    en2 = 1'b1; trig2 = 1'b0; vol2 = '0;
    test_reset();
    test_full_sequence();
    test_density();
    test_trigger_while_busy();
    test_rearm();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
